// File: rtl/inst_seq_pkg.sv
// rtl/inst_seq_pkg.sv - State encoding and default watchdog sizing for the instruction sequencer
package inst_seq_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
  localparam int unsigned TO_W_DEF           = 9;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_FWAIT = 4'd2,
    S_DEC   = 4'd3,
    S_MREQ  = 4'd4,
    S_MWAIT = 4'd5,
    S_WB    = 4'd6,
    S_HALT  = 4'd7,
    S_ERR   = 4'd8
  } seq_state_e;

  // States that wait on an external handshake and are therefore watched.
  function automatic logic is_wait_state(seq_state_e s);
    return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MREQ) || (s == S_MWAIT);
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// rtl/seq_wdog.sv - Saturating stall watchdog; expire_o flags the last permitted cycle of a wait
module seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned     LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TO_W-1:0] LAST   = LAST_I[TO_W-1:0];

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Holding at LAST keeps the counter from wrapping; with TIMEOUT_CYCLES=0 it never leaves 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/inst_seq_ctrl.sv
// rtl/inst_seq_ctrl.sv - Multi-cycle fetch/decode/memory/write-back sequencer for RV32E/Zicsr
// Optional INST_SEQ_PERF_EN adds perf_cycle/perf_instret counters.
module inst_seq_ctrl
  import inst_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = TO_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic        ifu_resp_err,
  output logic        ifu_resp_ready,
  output logic        inst_latch_en,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_rd_we,
  input  logic        dec_csr_we,
  input  logic        dec_is_ebreak,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  input  logic        lsu_resp_err,
  output logic        lsu_resp_ready,
  output logic        load_latch_en,
  output logic        rd_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic        commit,
  output logic        halted,
  output logic        err
`ifdef INST_SEQ_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  seq_state_e state_q, state_d;
  logic       wd_en, wd_clr, wd_expire;

  assign wd_en  = is_wait_state(state_q);
  assign wd_clr = (state_d != state_q);

  seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All outputs decode from state_q, so an async reset drops every gated write at once.
  always_comb begin
    state_d        = state_q;
    ifu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0;
    inst_latch_en  = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_wen    = 1'b0;
    lsu_resp_ready = 1'b0;
    load_latch_en  = 1'b0;
    rd_we          = 1'b0;
    csr_we         = 1'b0;
    pc_we          = 1'b0;
    commit         = 1'b0;
    halted         = 1'b0;
    err            = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d = S_FWAIT;
        end else if (wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_FWAIT: begin
        ifu_resp_ready = 1'b1;
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_d = S_ERR;
          end else begin
            inst_latch_en = 1'b1;
            state_d       = S_DEC;
          end
        end else if (wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_DEC: begin
        if (dec_is_ebreak) begin
          state_d = S_HALT;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MREQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = dec_mem_write;
        if (lsu_req_ready) begin
          state_d = S_MWAIT;
        end else if (wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_MWAIT: begin
        lsu_resp_ready = 1'b1;
        if (lsu_resp_valid) begin
          if (lsu_resp_err) begin
            state_d = S_ERR;
          end else begin
            load_latch_en = dec_mem_read;
            state_d       = S_WB;
          end
        end else if (wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rd_we   = dec_rd_we;
        csr_we  = dec_csr_we;
        pc_we   = 1'b1;
        commit  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  err    = 1'b1;
      default: state_d = S_ERR;
    endcase
  end

`ifdef INST_SEQ_PERF_EN
  logic [63:0] perf_cycle_q, perf_instret_q;
  logic        active_d;

  // Counting on entry makes the visible value include the cycle currently in progress.
  assign active_d = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      if (active_d) begin
        perf_cycle_q <= perf_cycle_q + 64'd1;
      end
      if (commit) begin
        perf_instret_q <= perf_instret_q + 64'd1;
      end
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the RV32E/Zicsr core, sitting between the IFU, the LSU and the combinational decode/control generator. It steps each instruction through fetch, decode/execute, optional memory access and write-back over valid/ready handshakes. It also gates the decoder's write enables (GPR, CSR, PC, memory) so each fires exactly once per instruction. A watchdog traps stalled handshakes, and ebreak or bus errors halt the core.

Parameters:
TIMEOUT_CYCLES, 256, cycles a handshake may stall before ERR; 0 disables the watchdog
TO_W, 9, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  out  1  fetch request
ifu_req_ready  in  1  IFU accepts request
ifu_resp_valid  in  1  instruction word available
ifu_resp_err  in  1  fetch bus error, qualified by ifu_resp_valid
ifu_resp_ready  out  1  sequencer accepts instruction
inst_latch_en  out  1  load IR from IFU data
dec_mem_read  in  1  decoded load
dec_mem_write  in  1  decoded store
dec_rd_we  in  1  decoded GPR write
dec_csr_we  in  1  decoded CSR write
dec_is_ebreak  in  1  decoded ebreak
lsu_req_valid  out  1  memory request
lsu_req_wen  out  1  1 = store, 0 = load
lsu_req_ready  in  1  LSU accepts request
lsu_resp_valid  in  1  LSU done
lsu_resp_err  in  1  LSU bus error, qualified by lsu_resp_valid
lsu_resp_ready  out  1  sequencer accepts LSU response
load_latch_en  out  1  capture load data
rd_we  out  1  gated GPR write
csr_we  out  1  gated CSR write
pc_we  out  1  PC update
commit  out  1  instruction retired pulse
halted  out  1  sticky; set by ebreak
err  out  1  sticky; set by bus error or timeout

Behaviour:
- States: IDLE, FETCH, FWAIT, DEC, MREQ, MWAIT, WB, HALT, ERR.
- Async reset: state=IDLE, watchdog=0, all outputs 0. IDLE -> FETCH unconditionally on the first clock after reset release.
- A reset asserted mid-instruction abandons the instruction; no gated write fires after rst_n falls.
- FETCH: ifu_req_valid=1, held until ifu_req_ready. On handshake -> FWAIT.
- FWAIT: ifu_resp_ready=1.
  - On ifu_resp_valid with err=0: inst_latch_en=1 for that cycle, -> DEC.
  - On ifu_resp_valid with err=1: -> ERR, no latch.
- DEC: one cycle for decode/ALU settle. Priority: dec_is_ebreak -> HALT; else (dec_mem_read | dec_mem_write) -> MREQ; else -> WB.
- MREQ: lsu_req_valid=1 and lsu_req_wen=dec_mem_write, both held stable until lsu_req_ready. On handshake -> MWAIT.
- MWAIT: lsu_resp_ready=1.
  - On lsu_resp_valid with err=0: load_latch_en=1 if the instruction is a load, then -> WB.
  - On lsu_resp_valid with err=1: -> ERR.
- WB: exactly one cycle. rd_we=dec_rd_we, csr_we=dec_csr_we, pc_we=1, commit=1, then -> FETCH. These outputs are 0 in every other state.
- HALT and ERR: absorbing until reset. halted=1 in HALT, err=1 in ERR. All request, ready and write outputs are 0. No commit for ebreak.
- Latency with zero-wait IFU/LSU:
  - ALU instruction: 4 cycles, FETCH -> FWAIT -> DEC -> WB.
  - Load or store: 6 cycles.
  - commit is spaced at least 4 cycles apart.
- Watchdog:
  - Counts cycles in FETCH, FWAIT, MREQ and MWAIT.
  - Cleared on every state change.
  - When count == TIMEOUT_CYCLES-1 and the awaited handshake is absent that cycle, -> ERR.
  - A handshake in the same cycle as expiry wins: no ERR.
  - Saturates; never wraps. TIMEOUT_CYCLES=0 disables it.
- Decoder inputs are sampled only in DEC, MREQ, MWAIT and WB. The IR is stable in those states.
- A response valid arriving in a state that is not waiting for it is ignored.

Optional Feature:
Macro INST_SEQ_PERF_EN.
- When defined, adds outputs perf_cycle[63:0] and perf_instret[63:0].
  - perf_cycle counts every clock outside IDLE/HALT/ERR.
  - perf_instret increments on commit.
  - Both reset to 0 asynchronously and wrap modulo 2^64.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package inst_seq_pkg holds the state enum (seq_state_e, 4-bit encoding) and the default TIMEOUT_CYCLES constant.
- One sub-module, seq_wdog: clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES and TO_W.
- The FSM stays in inst_seq_ctrl.

Test Plan:
- Zero-wait IFU, add decoded (rd_we=1) -> commit, rd_we and pc_we each high for exactly one cycle, on cycle 4 after FETCH entry; repeat 10 times -> 10 commits in 40 cycles.
- Load, LSU ready after 3 cycles, response 2 cycles later -> lsu_req_valid held 3 cycles, load_latch_en one pulse, then WB with rd_we=1; store -> lsu_req_wen=1, rd_we=0 in WB.
- ifu_req_ready held low, TIMEOUT_CYCLES=8 -> err=1 after exactly 8 FETCH cycles. Variant: ready asserted on cycle 8 -> no err, FWAIT entered.
- dec_is_ebreak in DEC -> halted=1, no commit; all outputs stay 0 for 20 more cycles.
- lsu_resp_err with valid in MWAIT -> ERR, rd_we never asserted. Then pulse rst_n low mid-state -> IDLE, all outputs 0, FETCH one cycle after release.
- INST_SEQ_PERF_EN defined, 5 ALU instructions zero-wait -> perf_instret=5, perf_cycle=21 (IDLE excluded, includes the current FETCH).
